// File: rtl/clock_step_controller_pkg.sv
// clock_step_controller_pkg: shared prescale default, FSM states and request encodings
package clock_step_controller_pkg;
  localparam int unsigned CPU_CLK_PRESCALE = 32'd50;
  typedef enum logic [1:0] {HALT = 2'd0, RUN = 2'd1, STEP = 2'd2} state_t;
  // Encoded so that a larger value is a higher-priority request
  typedef enum logic [1:0] {REQ_NONE = 2'd0, REQ_RUN = 2'd1, REQ_STEP = 2'd2, REQ_HALT = 2'd3} req_t;
  function automatic req_t req_max(input req_t a, input req_t b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/clock_step_controller_if.sv
// clock_step_controller_if: debug control inputs and CPU/RAM enable outputs of the sequencer
interface clock_step_controller_if #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned PRESCALE = 50
);
  logic                        run_req;
  logic                        halt_req;
  logic                        step_req;
  logic                        bp_en;
  logic [ADDR_W-1:0]           bp_addr;
  logic [ADDR_W-1:0]           pc;
  logic                        ram_en;
  logic                        cpu_en;
  logic                        running;
  logic                        bp_hit;
  logic [31:0]                 cycle_count;
  logic [$clog2(PRESCALE)-1:0] phase;
  modport master (
    output run_req, halt_req, step_req, bp_en, bp_addr, pc,
    input  ram_en, cpu_en, running, bp_hit, cycle_count, phase
  );
  modport slave (
    input  run_req, halt_req, step_req, bp_en, bp_addr, pc,
    output ram_en, cpu_en, running, bp_hit, cycle_count, phase
  );
endinterface

// File: rtl/clock_step_controller_phase_counter.sv
// clock_phase_counter: free-running 0..PRESCALE-1 phase counter; ram/cpu strobes fire one cycle ahead of their phase
module clock_phase_counter #(
  parameter int unsigned PRESCALE = 50
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic [$clog2(PRESCALE)-1:0] cnt,
  output logic                        period_start,
  output logic                        ram_phase,
  output logic                        cpu_phase
);
  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] LAST    = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] RAM_PRE = CW'(PRESCALE / 2 - 2);
  localparam logic [CW-1:0] CPU_PRE = CW'(PRESCALE - 2);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else        cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
  assign period_start = cnt == '0;
  assign ram_phase    = cnt == RAM_PRE;
  assign cpu_phase    = cnt == CPU_PRE;
endmodule

// File: rtl/clock_step_controller.sv
// clock_step_controller: run/halt/step/breakpoint gating of paired RAM and CPU enable pulses
module clock_step_controller
  import clock_step_controller_pkg::*;
#(
  parameter int unsigned PRESCALE = CPU_CLK_PRESCALE,
  parameter int unsigned ADDR_W   = 32
) (
  input logic                    clk,
  input logic                    rst_n,
  clock_step_controller_if.slave bus
);
  state_t                      state, state_nxt;
  req_t                        pend, pend_nxt, req_in, eff;
  logic                        granted, granted_nxt;
  logic                        bp_skip, skip_set, hit_set, hit_clr, bp_match;
  logic                        period_start, ram_phase, cpu_phase;
  logic [$clog2(PRESCALE)-1:0] cnt;
  clock_phase_counter #(.PRESCALE(PRESCALE)) u_phase (
    .clk         (clk),
    .rst_n       (rst_n),
    .cnt         (cnt),
    .period_start(period_start),
    .ram_phase   (ram_phase),
    .cpu_phase   (cpu_phase)
  );
  assign bus.phase   = cnt;
  assign bus.running = state == RUN;
  assign bp_match    = bus.pc[ADDR_W-1:0] == bus.bp_addr[ADDR_W-1:0];
  // A request arriving in the period-start cycle itself takes part in that decision
  always_comb begin
    req_in      = bus.halt_req ? REQ_HALT : bus.step_req ? REQ_STEP : bus.run_req ? REQ_RUN : REQ_NONE;
    eff         = req_max(pend, req_in);
    pend_nxt    = period_start ? REQ_NONE : eff;
    state_nxt   = state;
    granted_nxt = granted;
    skip_set    = 1'b0;
    hit_set     = 1'b0;
    hit_clr     = 1'b0;
    if (period_start) begin
      granted_nxt = 1'b0;
      if (state == RUN) begin
        if (eff == REQ_HALT) state_nxt = HALT;
        else if (bus.bp_en && bp_match && !bp_skip) begin
          state_nxt = HALT;
          hit_set   = 1'b1;
        end else granted_nxt = 1'b1;
      end else if (eff == REQ_RUN || eff == REQ_STEP) begin
        state_nxt   = (eff == REQ_RUN) ? RUN : STEP;
        granted_nxt = 1'b1;
        skip_set    = 1'b1;
        hit_clr     = 1'b1;
      end else state_nxt = HALT;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state           <= HALT;
      pend            <= REQ_NONE;
      granted         <= 1'b0;
      bp_skip         <= 1'b0;
      bus.bp_hit      <= 1'b0;
      bus.ram_en      <= 1'b0;
      bus.cpu_en      <= 1'b0;
      bus.cycle_count <= '0;
    end else begin
      state      <= state_nxt;
      pend       <= pend_nxt;
      granted    <= granted_nxt;
      bp_skip    <= skip_set | (bp_skip & ~bus.cpu_en);
      bus.bp_hit <= hit_set | (bus.bp_hit & ~hit_clr);
      bus.ram_en <= granted_nxt & ram_phase;
      bus.cpu_en <= granted_nxt & cpu_phase;
      if (bus.cpu_en) bus.cycle_count <= bus.cycle_count + 32'd1;
    end
endmodule

// File: tb/tb_clock_step_controller.sv
// tb_clock_step_controller: period-level directed vectors plus a mid-period reset sequence, PRESCALE=8
module tb_clock_step_controller;
  localparam int P = 8;
  localparam int K_N = 0, K_RUN = 1, K_HALT = 2, K_STEP = 3, K_HS = 4, K_SR = 5, K_RS = 6;
  typedef struct {
    int          kind;
    int          rc;
    logic        bp_en;
    logic [31:0] pc;
    logic        g;
    logic        r;
    logic        h;
    logic [31:0] cc;
  } vec_t;
  logic clk, rst_n;
  int   n_cmp, n_err;
  vec_t vt[$];
  clock_step_controller_if #(.ADDR_W(32), .PRESCALE(P)) bus ();
  clock_step_controller #(.PRESCALE(P), .ADDR_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic add(input int k, input int rc, input logic bp, input logic [31:0] pc,
                     input logic g, input logic r, input logic h, input logic [31:0] cc);
    vt.push_back('{k, rc, bp, pc, g, r, h, cc});
  endtask
  // Runs one full period starting in the cycle where cnt==0
  task automatic do_period(input int idx, input vec_t v);
    logic [7:0] ram_seen, cpu_seen;
    logic       ph_ok;
    ph_ok      = 1'b1;
    bus.bp_en  = v.bp_en;
    bus.pc     = v.pc;
    bus.bp_addr = 32'h10;
    for (int c = 0; c < P; c++) begin
      bus.run_req  = ((v.kind == K_RUN || v.kind == K_RS) && c == v.rc) || (v.kind == K_SR && c == v.rc + 2);
      bus.step_req = ((v.kind == K_STEP || v.kind == K_HS || v.kind == K_SR) && c == v.rc) || (v.kind == K_RS && c == v.rc + 2);
      bus.halt_req = (v.kind == K_HALT || v.kind == K_HS) && c == v.rc;
      ram_seen[c]  = bus.ram_en;
      cpu_seen[c]  = bus.cpu_en;
      if (bus.phase !== 3'(c)) ph_ok = 1'b0;
      if (c == 1) begin
        chk($sformatf("row%0d running", idx), {31'd0, bus.running}, {31'd0, v.r});
        chk($sformatf("row%0d bp_hit", idx), {31'd0, bus.bp_hit}, {31'd0, v.h});
      end
      tick;
    end
    bus.run_req  = 1'b0;
    bus.step_req = 1'b0;
    bus.halt_req = 1'b0;
    chk($sformatf("row%0d ram_en pattern", idx), {24'd0, ram_seen}, v.g ? 32'h08 : 32'h00);
    chk($sformatf("row%0d cpu_en pattern", idx), {24'd0, cpu_seen}, v.g ? 32'h80 : 32'h00);
    chk($sformatf("row%0d phase sequence", idx), {31'd0, ph_ok}, 32'd1);
    chk($sformatf("row%0d cycle_count", idx), bus.cycle_count, v.cc);
  endtask
  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.run_req = 1'b0;
    bus.halt_req = 1'b0;
    bus.step_req = 1'b0;
    bus.bp_en = 1'b0;
    bus.bp_addr = 32'h10;
    bus.pc = 32'h0;
    for (int i = 0; i < 5; i++) add(K_N, 0, 0, 32'h0, 0, 0, 0, 0);
    add(K_RUN,  5, 0, 32'h00, 0, 0, 0, 0);
    add(K_N,    0, 0, 32'h00, 1, 1, 0, 1);
    add(K_N,    0, 0, 32'h00, 1, 1, 0, 2);
    add(K_N,    0, 0, 32'h00, 1, 1, 0, 3);
    add(K_N,    0, 0, 32'h00, 1, 1, 0, 4);
    add(K_HS,   6, 0, 32'h00, 1, 1, 0, 5);
    add(K_N,    0, 0, 32'h00, 0, 0, 0, 5);
    add(K_STEP, 2, 0, 32'h00, 0, 0, 0, 5);
    add(K_N,    0, 0, 32'h00, 1, 0, 0, 6);
    add(K_N,    0, 0, 32'h00, 0, 0, 0, 6);
    add(K_STEP, 4, 0, 32'h00, 0, 0, 0, 6);
    add(K_N,    0, 0, 32'h00, 1, 0, 0, 7);
    add(K_N,    0, 0, 32'h00, 0, 0, 0, 7);
    add(K_RUN,  1, 1, 32'h0C, 0, 0, 0, 7);
    add(K_N,    0, 1, 32'h0C, 1, 1, 0, 8);
    add(K_N,    0, 1, 32'h10, 0, 0, 1, 8);
    add(K_RUN,  3, 1, 32'h10, 0, 0, 1, 8);
    add(K_N,    0, 1, 32'h10, 1, 1, 0, 9);
    add(K_RUN,  2, 1, 32'h14, 1, 1, 0, 10);
    add(K_HALT, 7, 1, 32'h14, 1, 1, 0, 11);
    add(K_N,    0, 1, 32'h14, 0, 0, 0, 11);
    add(K_SR,   1, 0, 32'h00, 0, 0, 0, 11);
    add(K_N,    0, 0, 32'h00, 1, 0, 0, 12);
    add(K_N,    0, 0, 32'h00, 0, 0, 0, 12);
    add(K_RS,   1, 0, 32'h00, 0, 0, 0, 12);
    add(K_N,    0, 0, 32'h00, 1, 0, 0, 13);
    add(K_N,    0, 0, 32'h00, 0, 0, 0, 13);
    add(K_RUN,  1, 0, 32'h10, 0, 0, 0, 13);
    add(K_N,    0, 0, 32'h10, 1, 1, 0, 14);
    add(K_HALT, 3, 0, 32'h10, 1, 1, 0, 15);
    add(K_N,    0, 0, 32'h10, 0, 0, 0, 15);
    add(K_RUN,  1, 0, 32'h00, 0, 0, 0, 15);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset phase", {29'd0, bus.phase}, 32'd0);
    chk("reset ram_en", {31'd0, bus.ram_en}, 32'd0);
    chk("reset cpu_en", {31'd0, bus.cpu_en}, 32'd0);
    chk("reset running", {31'd0, bus.running}, 32'd0);
    chk("reset bp_hit", {31'd0, bus.bp_hit}, 32'd0);
    chk("reset cycle_count", bus.cycle_count, 32'd0);
    for (int i = 0; i < vt.size(); i++) do_period(i, vt[i]);
    repeat (3) tick;
    chk("midreset ram_en before", {31'd0, bus.ram_en}, 32'd1);
    chk("midreset running before", {31'd0, bus.running}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset ram_en async drop", {31'd0, bus.ram_en}, 32'd0);
    chk("midreset running", {31'd0, bus.running}, 32'd0);
    chk("midreset cycle_count", bus.cycle_count, 32'd0);
    repeat (6) @(posedge clk);
    chk("midreset cpu_en held", {31'd0, bus.cpu_en}, 32'd0);
    #1 rst_n = 1'b1;
    chk("release phase", {29'd0, bus.phase}, 32'd0);
    do_period(100, '{K_N, 0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'd0});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
